// File: rtl/lifo_stack.sv
// Single-clock LIFO stack with registered top-of-stack output and one-cycle done pulse.
// Optional sticky overflow/underflow flags are enabled by defining STACK_ERR_FLAGS_EN.
module lifo_stack #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16,
   localparam int unsigned AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   input  logic             err_clr,
   output logic [WIDTH-1:0] dout,
   output logic             done,
   output logic             full,
   output logic             empty,
   output logic [AW:0]      count,
   output logic             ovf,
   output logic             unf
);

   localparam logic [AW:0] CntOne   = (AW + 1)'(1);
   localparam logic [AW:0] CntTwo   = (AW + 1)'(2);
   localparam logic [AW:0] CntDepth = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];

   logic [AW:0]      count_q, count_d;
   logic [WIDTH-1:0] dout_q, dout_d;
   logic             done_q, done_d;

   logic             wr_en;
   logic [AW-1:0]    wr_addr;
   logic             ovf_evt, unf_evt;
   logic             is_empty, is_full;
   logic [AW:0]      cnt_m1, cnt_m2;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CntDepth);
   assign cnt_m1   = count_q - CntOne;
   assign cnt_m2   = count_q - CntTwo;

   always_comb begin
      count_d = count_q;
      dout_d  = dout_q;
      done_d  = 1'b0;
      wr_en   = 1'b0;
      wr_addr = count_q[AW-1:0];
      ovf_evt = 1'b0;
      unf_evt = 1'b0;

      if (push && pop && !is_empty) begin
         // Exchange: overwrite the top entry in place.
         wr_en   = 1'b1;
         wr_addr = cnt_m1[AW-1:0];
         dout_d  = din;
         done_d  = 1'b1;
      end else if (push) begin
         if (!is_full) begin
            wr_en   = 1'b1;
            count_d = count_q + CntOne;
            dout_d  = din;
            done_d  = 1'b1;
         end else begin
            ovf_evt = 1'b1;
         end
      end else if (pop) begin
         if (!is_empty) begin
            count_d = cnt_m1;
            // Entry below the current top becomes visible; nothing left means 0.
            dout_d  = (count_q > CntOne) ? mem[cnt_m2[AW-1:0]] : '0;
            done_d  = 1'b1;
         end else begin
            unf_evt = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
         dout_q  <= '0;
         done_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         dout_q  <= dout_d;
         done_q  <= done_d;
      end
   end

   // Storage is not cleared on reset; dout is zeroed instead.
   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem[wr_addr] <= din;
      end
   end

   assign dout  = dout_q;
   assign done  = done_q;
   assign count = count_q;
   assign empty = is_empty;
   assign full  = is_full;

`ifdef STACK_ERR_FLAGS_EN
   logic ovf_q, unf_q;

   // A new event wins over a coincident clear.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_evt | (ovf_q & ~err_clr);
         unf_q <= unf_evt | (unf_q & ~err_clr);
      end
   end

   assign ovf = ovf_q;
   assign unf = unf_q;
`else
   logic unused_flags;
   assign unused_flags = ^{err_clr, ovf_evt, unf_evt};
   assign ovf = 1'b0;
   assign unf = 1'b0;
`endif

endmodule

// File: tb/tb_lifo_stack.sv
// Self-checking bench for lifo_stack: directed scenarios plus randomized traffic against a
// queue-based reference model. Flag expectations follow STACK_ERR_FLAGS_EN.
module tb_lifo_stack;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst, push, pop, err_clr;
   logic [WIDTH-1:0] din;
   logic [WIDTH-1:0] dout;
   logic             done, full, empty, ovf, unf;
   logic [AW:0]      count;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   logic [WIDTH-1:0] model_q[$];
   logic             m_done, m_ovf, m_unf;

   lifo_stack #(
      .WIDTH(WIDTH),
      .DEPTH(DEPTH)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .push   (push),
      .pop    (pop),
      .din    (din),
      .err_clr(err_clr),
      .dout   (dout),
      .done   (done),
      .full   (full),
      .empty  (empty),
      .count  (count),
      .ovf    (ovf),
      .unf    (unf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   function automatic logic flags_on();
`ifdef STACK_ERR_FLAGS_EN
      return 1'b1;
`else
      return 1'b0;
`endif
   endfunction

   // Apply one cycle of stimulus, advance the model, and compare every output.
   task automatic do_cycle(input logic p, input logic po, input logic [WIDTH-1:0] d,
                           input logic r, input logic ec);
      logic ovf_evt, unf_evt;
      logic [WIDTH-1:0] exp_dout;
      push = p; pop = po; din = d; rst = r; err_clr = ec;
      @(posedge clk);
      #1;
      ovf_evt = 1'b0;
      unf_evt = 1'b0;
      m_done  = 1'b0;
      if (r) begin
         model_q.delete();
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else begin
         if (p && po && model_q.size() > 0) begin
            model_q[model_q.size() - 1] = d;
            m_done = 1'b1;
         end else if (p) begin
            if (model_q.size() < DEPTH) begin
               model_q.push_back(d);
               m_done = 1'b1;
            end else begin
               ovf_evt = 1'b1;
            end
         end else if (po) begin
            if (model_q.size() > 0) begin
               void'(model_q.pop_back());
               m_done = 1'b1;
            end else begin
               unf_evt = 1'b1;
            end
         end
         if (flags_on()) begin
            m_ovf = ovf_evt | (m_ovf & ~ec);
            m_unf = unf_evt | (m_unf & ~ec);
         end
      end
      exp_dout = (model_q.size() > 0) ? model_q[model_q.size() - 1] : '0;
      check_eq("dout",  32'(dout),  32'(exp_dout));
      check_eq("count", 32'(count), 32'(model_q.size()));
      check_eq("empty", 32'(empty), 32'(model_q.size() == 0));
      check_eq("full",  32'(full),  32'(model_q.size() == DEPTH));
      check_eq("done",  32'(done),  32'(m_done));
      check_eq("ovf",   32'(ovf),   32'(m_ovf));
      check_eq("unf",   32'(unf),   32'(m_unf));
   endtask

   task automatic idle();
      do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      do_cycle(1'b0, 1'b0, '0, 1'b1, 1'b0);
   endtask

   initial begin
      rst = 1'b1; push = 1'b0; pop = 1'b0; din = '0; err_clr = 1'b0;
      m_ovf = 1'b0; m_unf = 1'b0; m_done = 1'b0;

      // Reset state
      do_reset();
      check_eq("rst_count", 32'(count), 0);
      check_eq("rst_empty", 32'(empty), 1);
      check_eq("rst_dout",  32'(dout),  0);
      idle();

      // Three pushes, then three pops and an underflow
      do_cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
      check_eq("push1_done", 32'(done), 1);
      do_cycle(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
      do_cycle(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
      check_eq("push3_dout",  32'(dout),  32'h33);
      check_eq("push3_count", 32'(count), 3);
      do_cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
      check_eq("pop1_dout", 32'(dout), 32'h22);
      do_cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
      check_eq("pop2_dout", 32'(dout), 32'h11);
      do_cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
      check_eq("pop3_empty", 32'(empty), 1);
      do_cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
      check_eq("unf_done", 32'(done), 0);
      check_eq("unf_flag", 32'(unf), 32'(flags_on()));
      do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check_eq("unf_clr", 32'(unf), 0);

      // Fill to capacity and overflow
      do_reset();
      for (int i = 0; i < DEPTH; i++) do_cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      do_cycle(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
      check_eq("ovf_full",  32'(full),  1);
      check_eq("ovf_count", 32'(count), 16);
      check_eq("ovf_dout",  32'(dout),  32'h0F);
      check_eq("ovf_done",  32'(done),  0);
      check_eq("ovf_flag",  32'(ovf),   32'(flags_on()));
      // Clear coincident with a fresh overflow keeps the flag
      do_cycle(1'b1, 1'b0, 8'hAB, 1'b0, 1'b1);
      check_eq("ovf_hold", 32'(ovf), 32'(flags_on()));
      do_cycle(1'b0, 1'b0, '0, 1'b0, 1'b1);
      check_eq("ovf_clr", 32'(ovf), 0);
      // Drain fully to confirm contents survived the rejected pushes
      for (int i = DEPTH - 1; i >= 0; i--) do_cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);

      // Exchange on a two-entry stack
      do_reset();
      do_cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
      do_cycle(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
      do_cycle(1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
      check_eq("xchg_count", 32'(count), 2);
      check_eq("xchg_dout",  32'(dout),  32'h99);
      do_cycle(1'b0, 1'b1, '0, 1'b0, 1'b0);
      check_eq("xchg_pop", 32'(dout), 32'h11);

      // Push+pop on empty acts as a push
      do_reset();
      do_cycle(1'b1, 1'b1, 8'h5A, 1'b0, 1'b0);
      check_eq("pp_empty_count", 32'(count), 1);
      check_eq("pp_empty_dout",  32'(dout),  32'h5A);
      check_eq("pp_empty_done",  32'(done),  1);

      // Reset wins over a coincident push
      do_reset();
      do_cycle(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
      do_cycle(1'b1, 1'b0, 8'h22, 1'b0, 1'b0);
      do_cycle(1'b1, 1'b0, 8'h77, 1'b1, 1'b0);
      check_eq("rstpush_count", 32'(count), 0);
      check_eq("rstpush_done",  32'(done),  0);
      check_eq("rstpush_dout",  32'(dout),  0);
      do_cycle(1'b1, 1'b0, 8'h44, 1'b0, 1'b0);
      check_eq("after_rst_dout",  32'(dout),  32'h44);
      check_eq("after_rst_count", 32'(count), 1);

      // Randomized traffic; push bias alternates so both full and empty are reached
      for (int i = 0; i < 600; i++) begin
         int unsigned bias;
         logic p, po, r, ec;
         bias = ((i / 60) % 2 == 0) ? 75 : 25;
         p  = ($urandom_range(99) < bias);
         po = ($urandom_range(99) < (100 - bias));
         r  = ($urandom_range(199) == 0);
         ec = ($urandom_range(9) == 0);
         do_cycle(p, po, 8'($urandom), r, ec);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, expected completion before 200000");
      $fatal(1);
   end

endmodule

// File: doc/lifo_stack.md
LIFO_STACK -- requirements
Module: lifo_stack

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 16, SHALL set the number of entries (power of two, >=2); AW = clog2(DEPTH) is derived.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-005 push  input  1  SHALL request a push of din this cycle.
REQ-006 pop  input  1  SHALL request removal of the top entry this cycle.
REQ-007 din  input  WIDTH  SHALL be the data to push, sampled on the edge where push=1.
REQ-008 dout  output  WIDTH  SHALL be the current top-of-stack value, registered.
REQ-009 done  output  1  SHALL be a one-cycle pulse acknowledging an accepted operation.
REQ-010 full  output  1  SHALL be high when count == DEPTH.
REQ-011 empty  output  1  SHALL be high when count == 0.
REQ-012 count  output  AW+1  SHALL be the number of stored entries, 0..DEPTH.
REQ-013 ovf  output  1  SHALL be the sticky overflow flag (macro-dependent, REQ-032).
REQ-014 unf  output  1  SHALL be the sticky underflow flag (macro-dependent, REQ-032).
REQ-015 err_clr  input  1  SHALL clear ovf and unf (macro-dependent).

Function
REQ-016 Operations SHALL be sampled on each rising clk edge with rst=0; no multi-cycle state machine, one operation per cycle, back-to-back allowed.
REQ-017 push=1, pop=0, full=0: mem[count] <= din, count+1; accepted.
REQ-018 push=0, pop=1, empty=0: count-1; popped value was presented on dout in the cycle of the request; accepted.
REQ-019 push=1, pop=1, empty=0: replace top entry with din, count unchanged; accepted (exchange).
REQ-020 push=1, pop=1, empty=1: SHALL behave as a plain push; accepted.
REQ-021 push=1, pop=0, full=1: SHALL be ignored (memory and count unchanged); rejected; overflow event.
REQ-022 push=0, pop=1, empty=1: SHALL be ignored; rejected; underflow event.
REQ-023 done SHALL be 1 in the cycle after an accepted operation and 0 after a rejected or idle cycle.
REQ-024 dout SHALL reflect the new top entry in the cycle after the operation (1-cycle latency); dout SHALL be 0 whenever empty=1.
REQ-025 full, empty, count SHALL update on the same edge as the operation and never disagree with each other.
REQ-026 count SHALL never exceed DEPTH nor go below 0; no wrap-around of the stack pointer.
REQ-027 Memory contents below count SHALL be preserved across any number of exchanges, rejected operations and idle cycles.

Reset
REQ-028 rst=1 SHALL, on the next rising edge, set count=0, empty=1, full=0, done=0, dout=0, ovf=0, unf=0.
REQ-029 rst SHALL take priority over push/pop in the same cycle; an operation coincident with rst SHALL have no effect and produce no done.
REQ-030 Storage array contents need not be cleared on reset; no stale value SHALL be observable on dout.
REQ-031 Reset mid-sequence SHALL leave the block fully usable on the first cycle after rst deasserts.

Configuration
REQ-032 Macro STACK_ERR_FLAGS_EN defined: ovf/unf set on overflow/underflow events (REQ-021/022) and hold until err_clr=1 or rst; err_clr coincident with a new event SHALL leave the flag set.
REQ-033 STACK_ERR_FLAGS_EN undefined: ovf and unf SHALL be constant 0, err_clr SHALL be ignored; all other behaviour identical.

Verification (WIDTH=8, DEPTH=16)
REQ-034 Reset, then push 0x11,0x22,0x33 on consecutive cycles -> count=3, dout=0x33, done high three cycles, empty=0.
REQ-035 From REQ-034 state, pop three times -> dout 0x22, 0x11, then 0x00 with empty=1, count=0; a fourth pop -> done=0, count=0, unf=1 (flags enabled).
REQ-036 Push 16 values 0x00..0x0F then push 0xAA -> full=1, count=16, dout=0x0F, done=0 for the 17th, ovf=1; err_clr pulse -> ovf=0.
REQ-037 Stack holds 0x11,0x22; push=pop=1 with din=0x99 -> count=2, dout=0x99; pop -> dout=0x11.
REQ-038 Empty stack, push=pop=1 with din=0x5A -> count=1, dout=0x5A, done=1.
REQ-039 Push 0x11,0x22 then rst=1 together with push=1 -> count=0, dout=0, done=0, flags 0; then push 0x44 -> dout=0x44, count=1.
